// File: rtl/fec_pkg.sv
// Definitions shared across the FEC datapath blocks: framer FSM states and
// default framing constants.
package fec_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_WAIT  = 2'd2,
    ST_GAP   = 2'd3
  } framer_state_e;

  localparam int FEC_FRAME_BYTES = 188;
  localparam int FEC_GAP_CYCLES  = 4;

endpackage

// File: rtl/scrambler_framer.sv
// Byte-to-bit serializer feeding the scrambler: frames FRAME_BYTES payload bytes
// MSB first, flags frame start/end and forces GAP_CYCLES idle cycles between frames.
module scrambler_framer
  import fec_pkg::*;
#(
  parameter int FRAME_BYTES = FEC_FRAME_BYTES,
  parameter int GAP_CYCLES  = FEC_GAP_CYCLES
) (
  input  logic       iclk,
  input  logic       ireset,
  input  logic       isop,
  input  logic       ival,
  input  logic [7:0] idata,
  output logic       iready,
  output logic       osop,
  output logic       oval,
  output logic       odata,
  output logic       ofrm_done,
  output logic       oerr
);

  localparam int BW = $clog2(FRAME_BYTES);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [BW-1:0] LAST_BYTE = BW'(FRAME_BYTES - 1);
  localparam logic [GW-1:0] LAST_GAP  = GW'(GAP_CYCLES - 1);

  framer_state_e   state_q, state_d;
  logic [7:0]      sreg_q, sreg_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [BW-1:0]   byte_cnt_q, byte_cnt_d;
  logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
  logic            iready_q, iready_d;
  logic            osop_q, osop_d;
  logic            oval_q, oval_d;
  logic            odata_q, odata_d;
  logic            ofrm_done_q, ofrm_done_d;
  logic            oerr_q, oerr_d;
  logic            acc;
  logic            take;

  assign acc = ival & iready_q;

  always_comb begin
    state_d     = state_q;
    sreg_d      = sreg_q;
    bit_cnt_d   = bit_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    osop_d      = 1'b0;
    oval_d      = 1'b0;
    odata_d     = 1'b0;
    ofrm_done_d = 1'b0;
    oerr_d      = 1'b0;
    take        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (acc) begin
          if (isop) take = 1'b1;
          else      oerr_d = 1'b1;
        end
      end
      ST_SHIFT: begin
        oval_d    = 1'b1;
        odata_d   = sreg_q[7];
        osop_d    = (bit_cnt_q == 3'd0) && (byte_cnt_q == '0);
        sreg_d    = {sreg_q[6:0], 1'b0};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          if (byte_cnt_q == LAST_BYTE) begin
            ofrm_done_d = 1'b1;
            state_d     = ST_GAP;
            gap_cnt_d   = '0;
            byte_cnt_d  = '0;
          end else if (acc) begin
            take = 1'b1;
          end else begin
            // Starved mid-frame: hold with oval low so the scrambler LFSR stalls.
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        take = acc;
      end
      ST_GAP: begin
        if (gap_cnt_q == LAST_GAP) begin
          state_d   = ST_IDLE;
          gap_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A byte with isop outside IDLE truncates the running frame and restarts.
    if (take) begin
      state_d   = ST_SHIFT;
      sreg_d    = idata;
      bit_cnt_d = 3'd0;
      if (isop) begin
        byte_cnt_d = '0;
        oerr_d     = (state_q != ST_IDLE);
      end else begin
        byte_cnt_d = byte_cnt_q + BW'(1);
      end
    end
  end

  // Registered ready mirrors the next state so it is valid for the following edge.
  always_comb begin
    iready_d = (state_d == ST_IDLE) || (state_d == ST_WAIT) ||
               ((state_d == ST_SHIFT) && (bit_cnt_d == 3'd7) && (byte_cnt_d != LAST_BYTE));
  end

  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) begin
      state_q     <= ST_IDLE;
      sreg_q      <= '0;
      bit_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      iready_q    <= 1'b1;
      osop_q      <= 1'b0;
      oval_q      <= 1'b0;
      odata_q     <= 1'b0;
      ofrm_done_q <= 1'b0;
      oerr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      iready_q    <= iready_d;
      osop_q      <= osop_d;
      oval_q      <= oval_d;
      odata_q     <= odata_d;
      ofrm_done_q <= ofrm_done_d;
      oerr_q      <= oerr_d;
    end
  end

  assign iready    = iready_q;
  assign osop      = osop_q;
  assign oval      = oval_q;
  assign odata     = odata_q;
  assign ofrm_done = ofrm_done_q;
  assign oerr      = oerr_q;

endmodule

// File: tb/tb_scrambler_framer.sv
// Directed bench for scrambler_framer with 4-byte frames and a 2-cycle gap.
module tb_scrambler_framer;

  localparam int FB = 4;
  localparam int GC = 2;

  logic       iclk = 1'b0;
  logic       ireset = 1'b0;
  logic       isop = 1'b0;
  logic       ival = 1'b0;
  logic [7:0] idata = 8'h00;
  logic       iready, osop, oval, odata, ofrm_done, oerr;

  int n_chk = 0;
  int n_pass = 0;

  // monitor state
  int          cyc = 0;
  int          nbits, nsop, ndone, nerr, sop_at, done_at, first_cyc, last_cyc;
  logic [31:0] word;
  logic [7:0]  fb8;

  scrambler_framer #(.FRAME_BYTES(FB), .GAP_CYCLES(GC)) dut (
    .iclk(iclk), .ireset(ireset), .isop(isop), .ival(ival), .idata(idata),
    .iready(iready), .osop(osop), .oval(oval), .odata(odata),
    .ofrm_done(ofrm_done), .oerr(oerr)
  );

  always #5 iclk = ~iclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got %0h exp %0h", tag, got, exp);
  endtask

  task automatic clr_mon();
    nbits = 0; nsop = 0; ndone = 0; nerr = 0; sop_at = 0; done_at = 0;
    first_cyc = 0; last_cyc = 0; word = '0; fb8 = '0;
  endtask

  task automatic tick();
    @(posedge iclk); #1;
    cyc++;
    if (oval) begin
      nbits++;
      word = {word[30:0], odata};
      if (nbits == 1) first_cyc = cyc;
      if (nbits == 8) fb8 = word[7:0];
      last_cyc = cyc;
    end
    if (osop) begin nsop++; sop_at = nbits; end
    if (ofrm_done) begin ndone++; done_at = nbits; end
    if (oerr) nerr++;
  endtask

  task automatic idle(input int n);
    ival = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_rdy(input string tag);
    int n = 0;
    while (!iready && n < 40) begin tick(); n++; end
    chk(tag, {31'd0, iready}, 32'd1);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic s);
    ival = 1'b1; idata = b; isop = s;
    wait_rdy("rdy_tmo");
    tick();
  endtask

  initial begin
    // reset state
    repeat (2) @(posedge iclk);
    #1;
    chk("rst_outs", {27'd0, osop, oval, odata, ofrm_done, oerr}, 32'd0);
    chk("rst_rdy", {31'd0, iready}, 32'd1);
    ireset = 1'b1;
    tick();

    // back-to-back frame
    clr_mon();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h3C, 1'b0);
    send_byte(8'hFF, 1'b0);
    send_byte(8'h00, 1'b0);
    idle(8);
    chk("b2b_done_now", {31'd0, ofrm_done}, 32'd1);
    chk("b2b_gap_rdy0", {31'd0, iready}, 32'd0);
    tick();
    chk("b2b_gap_rdy1", {30'd0, iready, oval}, 32'd0);
    tick();
    chk("b2b_idle_rdy", {31'd0, iready}, 32'd1);
    chk("b2b_nbits", nbits, 32);
    chk("b2b_span", last_cyc - first_cyc + 1, 32);
    chk("b2b_first8", {24'd0, fb8}, 32'hA5);
    chk("b2b_word", word, 32'hA53CFF00);
    chk("b2b_nsop", nsop, 1);
    chk("b2b_sop_at", sop_at, 1);
    chk("b2b_ndone", ndone, 1);
    chk("b2b_done_at", done_at, 32);
    chk("b2b_nerr", nerr, 0);

    // starved after second byte: three WAIT cycles
    clr_mon();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h3C, 1'b0);
    ival = 1'b0;
    wait_rdy("wait_rdy_tmo");
    idle(3);
    send_byte(8'hFF, 1'b0);
    send_byte(8'h00, 1'b0);
    idle(14);
    chk("wait_nbits", nbits, 32);
    chk("wait_span", last_cyc - first_cyc + 1, 35);
    chk("wait_word", word, 32'hA53CFF00);
    chk("wait_nsop", nsop, 1);
    chk("wait_ndone", ndone, 1);
    chk("wait_nerr", nerr, 0);

    // truncation by isop at the third byte
    clr_mon();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h3C, 1'b0);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b0);
    idle(14);
    chk("trunc_nbits", nbits, 48);
    chk("trunc_span", last_cyc - first_cyc + 1, 48);
    chk("trunc_nsop", nsop, 2);
    chk("trunc_sop_at", sop_at, 17);
    chk("trunc_ndone", ndone, 1);
    chk("trunc_done_at", done_at, 48);
    chk("trunc_word", word, 32'h11223344);
    chk("trunc_nerr", nerr, 1);

    // stray byte without isop in IDLE
    clr_mon();
    chk("stray_rdy", {31'd0, iready}, 32'd1);
    ival = 1'b1; idata = 8'h55; isop = 1'b0;
    tick();
    chk("stray_err", {30'd0, oerr, oval}, 32'd2);
    idle(4);
    chk("stray_err_cnt", nerr, 1);
    chk("stray_nbits", nbits, 0);
    chk("stray_rdy_after", {31'd0, iready}, 32'd1);

    // reset mid-frame at bit 13
    clr_mon();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h3C, 1'b0);
    idle(5);
    chk("mid_oval", {31'd0, oval}, 32'd1);
    ireset = 1'b0;
    #1;
    chk("mid_rst_outs", {27'd0, osop, oval, odata, ofrm_done, oerr}, 32'd0);
    idle(2);
    ireset = 1'b1;
    chk("mid_rel_rdy", {31'd0, iready}, 32'd1);
    clr_mon();
    ival = 1'b1; idata = 8'h77; isop = 1'b0;
    tick();
    chk("mid_rej_err", {31'd0, oerr}, 32'd1);
    idle(10);
    chk("mid_rej_nbits", nbits, 0);
    chk("mid_rej_nerr", nerr, 1);

    // recovery frame
    clr_mon();
    send_byte(8'hDE, 1'b1);
    send_byte(8'hAD, 1'b0);
    send_byte(8'hBE, 1'b0);
    send_byte(8'hEF, 1'b0);
    idle(14);
    chk("rec_nbits", nbits, 32);
    chk("rec_word", word, 32'hDEADBEEF);
    chk("rec_ndone", ndone, 1);
    chk("rec_nerr", nerr, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/scrambler_framer.md
SCRAMBLER_FRAMER -- requirements
Module: scrambler_framer

Interface
REQ-001 The block SHALL have parameter FRAME_BYTES, default 188, meaning payload bytes per frame (>=2).
REQ-002 The block SHALL have parameter GAP_CYCLES, default 4, meaning idle cycles forced after each frame (>=1).
REQ-003 The block SHALL have port iclk, input, 1 bit: the single clock.
REQ-004 The block SHALL have port ireset, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port isop, input, 1 bit: first byte of a frame, qualified by ival.
REQ-006 The block SHALL have port ival, input, 1 bit: idata valid.
REQ-007 The block SHALL have port idata, input, 8 bits: payload byte, serialized MSB first.
REQ-008 The block SHALL have port iready, output, 1 bit: a byte transfers when ival&iready.
REQ-009 The block SHALL have ports osop/oval/odata, outputs, 1 bit each: bit stream to the scrambler's isop/ival/idata.
REQ-010 The block SHALL have port ofrm_done, output, 1 bit: 1-cycle pulse coincident with the last bit of a complete frame.
REQ-011 The block SHALL have port oerr, output, 1 bit: 1-cycle pulse on a framing error.

Function
REQ-012 The block SHALL implement FSM states IDLE, SHIFT, WAIT and GAP.
REQ-013 In IDLE, iready SHALL be 1; an accepted byte with isop=1 SHALL load the shift register, clear byte_cnt and go to SHIFT.
REQ-014 In IDLE, an accepted byte with isop=0 SHALL be discarded, pulse oerr, and stay in IDLE.
REQ-015 In SHIFT, the block SHALL emit one bit per cycle (oval=1), bit_cnt 0..7, MSB first.
REQ-016 osop SHALL be 1 only with bit 0 of byte 0 of a frame.
REQ-017 Latency SHALL be 1 cycle: a byte accepted at edge N SHALL drive its first bit on oval/odata after edge N+1; all outputs SHALL be registered.
REQ-018 iready SHALL be 1 in SHIFT only when bit_cnt==7 and byte_cnt!=FRAME_BYTES-1, so back-to-back bytes give gap-free output.
REQ-019 At bit_cnt==7 with no byte accepted, on a non-last byte, the block SHALL go to WAIT with oval=0 and iready=1; the scrambler LFSR then holds.
REQ-020 In WAIT, an accepted byte with isop=0 SHALL continue the frame (byte_cnt+1, no osop).
REQ-021 An accepted byte with isop=1 in SHIFT or WAIT SHALL truncate the current frame, pulse oerr, and restart a frame (osop with its first bit, byte_cnt=0); ofrm_done SHALL NOT pulse for the truncated frame.
REQ-022 On the last bit of byte FRAME_BYTES-1, ofrm_done SHALL pulse and the FSM SHALL enter GAP.
REQ-023 GAP SHALL last exactly GAP_CYCLES cycles with oval=0, iready=0, then return to IDLE.
REQ-024 byte_cnt SHALL be $clog2(FRAME_BYTES) bits and SHALL never exceed FRAME_BYTES-1; gap_cnt SHALL be $clog2(GAP_CYCLES+1) bits.

Reset
REQ-025 ireset low SHALL immediately force the state to IDLE, all counters to 0, and osop, oval, odata, ofrm_done and oerr to 0.
REQ-026 After reset mid-frame, the next frame SHALL require isop; no partial state SHALL survive.

Structure
REQ-027 The FSM state enum and default FRAME_BYTES/GAP_CYCLES constants SHALL live in shared package fec_pkg.
REQ-028 The block SHALL have no sub-module; the parent SHALL instantiate scrambler and connect osop/oval/odata to its isop/ival/idata.

Verification (FRAME_BYTES=4, GAP_CYCLES=2)
REQ-029 Bytes A5,3C,FF,00 sent back-to-back, the first with isop -> 32 consecutive oval cycles; osop on cycle 1 only; odata begins 1,0,1,0,0,1,0,1; ofrm_done on cycle 32; then 2 cycles with iready=0.
REQ-030 ival low for 3 cycles after the 2nd byte -> oval=0 for 3 cycles (WAIT), then the stream resumes with no osop and a total of 32 bits.
REQ-031 isop accepted at the 3rd byte boundary -> oerr pulse; osop with the new first bit; the new frame outputs 32 bits; no ofrm_done for the old frame.
REQ-032 Byte 0x55 with isop=0 while IDLE -> accepted (iready=1), oerr pulse, oval stays 0.
REQ-033 ireset low at bit 13 -> all outputs 0 in the same cycle; after release iready=1; a byte without isop is rejected per REQ-014.
